spikecore_fifo: RTL and testbench



---
 rtl/spikecore_pkg.sv | 46 ++++
 rtl/spikecore_fifo_mem.sv | 38 +++
 rtl/spikecore_fifo.sv | 138 +++++++++++++
 tb/tb_spikecore_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/spikecore_pkg.sv
// Shared definitions for the spike-event FIFO: OBI payloads, command/status bit map.
package spikecore_pkg;

    localparam int unsigned SPK_DATA_W         = 32;
    localparam int unsigned SPK_N_DEFAULT      = 256;
    localparam int unsigned SPK_CMD_DONE_BIT   = 31;
    localparam int unsigned SPK_CMD_FLUSH_BIT  = 30;
    localparam int unsigned SPK_STAT_EMPTY_BIT = 0;
    localparam int unsigned SPK_STAT_FULL_BIT  = 1;
    localparam int unsigned SPK_STAT_DONE_BIT  = 2;
    localparam int unsigned SPK_STAT_OVF_BIT   = 3;
    localparam int unsigned SPK_STAT_LEVEL_LSB = 24;
    localparam int unsigned SPK_STAT_LEVEL_W   = 8;

    typedef logic [$clog2(SPK_N_DEFAULT)-1:0] spk_addr_t;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [SPK_DATA_W-1:0] wdata;
    } spk_obi_req_t;

    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic [SPK_DATA_W-1:0] rdata;
    } spk_obi_rsp_t;

    function automatic logic [SPK_DATA_W-1:0] spk_status(
        input logic [SPK_STAT_LEVEL_W-1:0] level,
        input logic                        ovf,
        input logic                        done,
        input logic                        full,
        input logic                        empty
    );
        logic [SPK_DATA_W-1:0] s;
        s = '0;
        s[SPK_STAT_LEVEL_LSB +: SPK_STAT_LEVEL_W] = level;
        s[SPK_STAT_OVF_BIT]   = ovf;
        s[SPK_STAT_DONE_BIT]  = done;
        s[SPK_STAT_FULL_BIT]  = full;
        s[SPK_STAT_EMPTY_BIT] = empty;
        return s;
    endfunction

endpackage

// File: rtl/spikecore_fifo_mem.sv
// DEPTH x W register array: synchronous write, registered read port that holds between reads.
module spikecore_fifo_mem
    import spikecore_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_d;
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) rdata_d = mem_q[raddr_i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spikecore_fifo.sv
// Host-fed spike-address FIFO with OBI slave port and charge-controller read interface.
// Build option SPIKECORE_DROP_ON_FULL_EN: drop pushes on full (sticky overflow) instead of stalling.
module spikecore_fifo
    import spikecore_pkg::*;
#(
    parameter int unsigned N     = 256,
    parameter int unsigned DEPTH = 32,
    parameter type         req_t = spk_obi_req_t,
    parameter type         rsp_t = spk_obi_rsp_t
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  req_t                       spike_slave_req_i,
    output rsp_t                       spike_slave_resp_o,
    input  logic                       spikecore_working_i,
    input  logic                       odin_done_i,
    input  logic                       spikecore_r_en_i,
    output logic [$clog2(N)-1:0]       spikecore_r_data_o,
    output logic                       spikecore_empty_o,
    output logic                       spikecore_done_o,
    output logic                       spikecore_full_o,
    output logic [$clog2(DEPTH):0]     spike_level_o
);

    localparam int unsigned AW = $clog2(N);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    logic [PW-1:0]         wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q, level_d, level_q;
    logic                  empty_d, empty_q, full_d, full_q, done_d, done_q;
    logic                  ovf_d, ovf_q, rvalid_d, rvalid_q;
    logic [SPK_DATA_W-1:0] rdata_d, rdata_q, wdata_c;
    logic                  req_c, we_c, flush_c, done_cmd_c, push_cmd_c;
    logic                  gnt_c, push_c, pop_c, read_c, clear_c;
    logic                  wdata_unused_c;

    // Command decode: FLUSH beats DONE, and either suppresses the push.
    always_comb begin
        req_c      = spike_slave_req_i.req;
        we_c       = spike_slave_req_i.we;
        wdata_c    = spike_slave_req_i.wdata;
        flush_c    = req_c && we_c && wdata_c[SPK_CMD_FLUSH_BIT];
        done_cmd_c = req_c && we_c && wdata_c[SPK_CMD_DONE_BIT] && !wdata_c[SPK_CMD_FLUSH_BIT];
        push_cmd_c = req_c && we_c && !wdata_c[SPK_CMD_DONE_BIT] && !wdata_c[SPK_CMD_FLUSH_BIT];
`ifdef SPIKECORE_DROP_ON_FULL_EN
        gnt_c      = req_c;
`else
        gnt_c      = req_c && !(push_cmd_c && full_q && spikecore_working_i);
`endif
        read_c     = req_c && !we_c;
        clear_c    = flush_c || !spikecore_working_i;
        push_c     = push_cmd_c && !full_q && !clear_c;
        pop_c      = spikecore_r_en_i && !empty_q && !clear_c;
    end

    assign wdata_unused_c = ^wdata_c;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_c);
        rd_ptr_d = rd_ptr_q + PW'(pop_c);
        if (clear_c) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
        level_d = wr_ptr_d - rd_ptr_d;
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[IW] != rd_ptr_d[IW]) && (wr_ptr_d[IW-1:0] == rd_ptr_d[IW-1:0]);

        // A DONE write outranks the controller's end-of-timestep clear.
        done_d = done_q;
        if (clear_c)            done_d = 1'b0;
        else if (done_cmd_c)    done_d = 1'b1;
        else if (odin_done_i)   done_d = 1'b0;

        ovf_d = 1'b0;
`ifdef SPIKECORE_DROP_ON_FULL_EN
        ovf_d = ovf_q;
        if (flush_c)                                        ovf_d = 1'b0;
        else if (push_cmd_c && full_q && spikecore_working_i) ovf_d = 1'b1;
        else if (read_c)                                    ovf_d = 1'b0;
`endif

        rvalid_d = gnt_c;
        rdata_d  = '0;
        if (read_c) rdata_d = spk_status(SPK_STAT_LEVEL_W'(level_q), ovf_q, done_q, full_q, empty_q);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    spikecore_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (AW)
    ) u_mem (
        .clk     (CLK),
        .rst_n   (RSTN),
        .we_i    (push_c),
        .waddr_i (wr_ptr_q[IW-1:0]),
        .wdata_i (wdata_c[AW-1:0]),
        .re_i    (pop_c),
        .raddr_i (rd_ptr_q[IW-1:0]),
        .rdata_o (spikecore_r_data_o)
    );

    always_comb begin
        spike_slave_resp_o        = '0;
        spike_slave_resp_o.gnt    = gnt_c;
        spike_slave_resp_o.rvalid = rvalid_q;
        spike_slave_resp_o.rdata  = rdata_q;
    end

    assign spikecore_empty_o = empty_q;
    assign spikecore_full_o  = full_q;
    assign spikecore_done_o  = done_q;
    assign spike_level_o     = level_q;

endmodule

// File: tb/tb_spikecore_fifo.sv
// Randomized + directed bench for spikecore_fifo against a queue-based reference model.
module tb_spikecore_fifo;
    import spikecore_pkg::*;

    localparam int N     = 256;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(N);

    logic               CLK = 1'b0;
    logic               RSTN;
    spk_obi_req_t       req_s;
    spk_obi_rsp_t       rsp_s;
    logic               working, odin, ren;
    logic [AW-1:0]      r_data;
    logic               empty, done, full;
    logic [5:0]         level;

    int errors = 0;
    int checks = 0;

    int q[$];
    int m_rdata;
    bit m_done, m_ovf;

    always #5 CLK = ~CLK;

    spikecore_fifo #(.N(N), .DEPTH(DEPTH)) dut (
        .CLK                 (CLK),
        .RSTN                (RSTN),
        .spike_slave_req_i   (req_s),
        .spike_slave_resp_o  (rsp_s),
        .spikecore_working_i (working),
        .odin_done_i         (odin),
        .spikecore_r_en_i    (ren),
        .spikecore_r_data_o  (r_data),
        .spikecore_empty_o   (empty),
        .spikecore_done_o    (done),
        .spikecore_full_o    (full),
        .spike_level_o       (level)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("r_data", 32'(r_data), 32'(m_rdata));
        check("empty",  32'(empty),  32'(q.size() == 0));
        check("full",   32'(full),   32'(q.size() == DEPTH));
        check("level",  32'(level),  32'(q.size()));
        check("done",   32'(done),   32'(m_done));
    endtask

    // One clock cycle: drive, check gnt, advance model, check registered outputs.
    task automatic cycle(input bit req, input bit we, input logic [31:0] wd,
                         input bit work, input bit od, input bit re);
        bit          is_full, fl, dn, ps, gnt, rd;
        logic [31:0] status;
        req_s.req = req; req_s.we = we; req_s.wdata = wd;
        working = work; odin = od; ren = re;
        #1;
        is_full = (q.size() == DEPTH);
        fl = req && we && wd[30];
        dn = req && we && wd[31] && !wd[30];
        ps = req && we && !wd[31] && !wd[30];
        rd = req && !we;
`ifdef SPIKECORE_DROP_ON_FULL_EN
        gnt = req;
`else
        gnt = req && !(ps && is_full && work);
`endif
        check("gnt", 32'(rsp_s.gnt), 32'(gnt));
        status = {8'(q.size()), 20'b0, m_ovf, m_done, is_full, q.size() == 0};

`ifdef SPIKECORE_DROP_ON_FULL_EN
        if (fl)                         m_ovf = 1'b0;
        else if (ps && is_full && work) m_ovf = 1'b1;
        else if (rd)                    m_ovf = 1'b0;
`endif
        if (!work || fl) begin
            q.delete();
            m_done = 1'b0;
        end else begin
            if (re && q.size() != 0) m_rdata = q.pop_front();
            if (ps && !is_full)      q.push_back(int'(wd[AW-1:0]));
            if (dn)                  m_done = 1'b1;
            else if (od)             m_done = 1'b0;
        end

        @(posedge CLK); #1;
        check("rvalid", 32'(rsp_s.rvalid), 32'(gnt));
        if (rd) check("status", rsp_s.rdata, status);
        check_outputs();
    endtask

    task automatic push(input int v, input bit re = 1'b0);
        cycle(1'b1, 1'b1, 32'(v), 1'b1, 1'b0, re);
    endtask
    task automatic cmd(input logic [31:0] wd);
        cycle(1'b1, 1'b1, wd, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic idle(input bit re = 1'b0, input bit od = 1'b0, input bit work = 1'b1);
        cycle(1'b0, 1'b0, 32'h0, work, od, re);
    endtask
    task automatic rd_status();
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        q.delete(); m_rdata = 0; m_done = 1'b0; m_ovf = 1'b0;
    endtask

    initial begin
        logic [31:0] wd;
        bit          rq, we, wk, od, re;
        int          ren_pct;

        RSTN = 1'b0; req_s = '0; working = 1'b1; odin = 1'b0; ren = 1'b0;
        model_reset();
        #12;
        check_outputs();
        check("rst_rvalid", 32'(rsp_s.rvalid), 32'd0);
        @(negedge CLK); RSTN = 1'b1;
        @(posedge CLK); #1;

        // Basic timestep list: 5, 9, 200, DONE, three pops.
        push(5); push(9); push(200); cmd(32'h8000_0000);
        idle(1'b1); check("pop0", 32'(r_data), 32'd5);
        idle(1'b1); check("pop1", 32'(r_data), 32'd9);
        idle(1'b1); check("pop2", 32'(r_data), 32'd200);
        check("empty_after_pops", 32'(empty), 32'd1);
        idle(); idle(1'b0, 1'b1);
        check("done_cleared", 32'(done), 32'd0);
        rd_status();

        // Fill, overfill while full, then pop to let the held push in.
        for (int i = 0; i < DEPTH; i++) push(i + 1);
        check("full_at_depth", 32'(full), 32'd1);
        push(99); push(99);
        rd_status();
        push(99, 1'b1);
        push(99);
        check("level_after_refill", 32'(level), 32'(DEPTH));
        rd_status(); rd_status();

        // Simultaneous push and pop with level 3.
        cmd(32'h4000_0000);
        push(1); push(2); push(3);
        push(17, 1'b1);
        check("level_stays_3", 32'(level), 32'd3);
        check("old_head", 32'(r_data), 32'd1);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("tail_17", 32'(r_data), 32'd17);

        // r_en on empty after a pop of 42; also push into empty with r_en.
        push(42); idle(1'b1); idle(1'b1); idle(1'b1);
        check("hold_42", 32'(r_data), 32'd42);
        push(7, 1'b1); idle(1'b1);

        // DONE and FLUSH in one word with level 4.
        for (int i = 0; i < 4; i++) push(60 + i);
        cmd(32'hC000_0000);
        check("flush_level", 32'(level), 32'd0);

        // Working low with level 6 and done set; pushes discarded meanwhile.
        for (int i = 0; i < 6; i++) push(80 + i);
        cmd(32'h8000_0000);
        idle(1'b0, 1'b0, 1'b0);
        check("wk_low_level", 32'(level), 32'd0);
        check("wk_low_done", 32'(done), 32'd0);
        cycle(1'b1, 1'b1, 32'd33, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'd34, 1'b0, 1'b0, 1'b1);
        push(35); idle(1'b1);
        check("after_wk", 32'(r_data), 32'd35);

        // DONE write coinciding with odin_done pulse.
        cycle(1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);

        // Randomized traffic in phases of differing pop pressure.
        for (int ph = 0; ph < 12; ph++) begin
            ren_pct = (ph % 2 == 0) ? 20 : 75;
            for (int i = 0; i < 250; i++) begin
                rq = ($urandom_range(99) < 60);
                we = ($urandom_range(99) < 80);
                wd = $urandom;
                wd[31] = ($urandom_range(99) < 3);
                wd[30] = ($urandom_range(199) < 1);
                wk = ($urandom_range(199) != 0);
                od = ($urandom_range(99) < 5);
                re = ($urandom_range(99) < ren_pct);
                cycle(rq, we, wd, wk, od, re);
            end
        end

        // Asynchronous reset mid-operation with a read in flight.
        push(11); push(12); rd_status();
        req_s.req = 1'b1; req_s.we = 1'b0;
        @(negedge CLK);
        RSTN = 1'b0; #1;
        model_reset();
        check_outputs();
        check("rst_rvalid_mid", 32'(rsp_s.rvalid), 32'd0);
        req_s = '0;
        @(negedge CLK); RSTN = 1'b1;
        @(posedge CLK); #1;
        push(77); idle(1'b1);
        check("post_reset_pop", 32'(r_data), 32'd77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
